// File: rtl/spart_pkg.sv
// Shared SPART definitions: bus register addresses, bit timing and the transmit state enum.
// Latency: none, this file holds declarations only.
// Backpressure: none. TX_PARITY_EN adds the TX_PARITY state when it is defined.
package spart_pkg;

    // ioaddr register map
    localparam logic [1:0] DATA    = 2'b00;
    localparam logic [1:0] STATUS  = 2'b01;
    localparam logic [1:0] DB_LOW  = 2'b10;
    localparam logic [1:0] DB_HIGH = 2'b11;

    // Oversample ticks per serial bit, and the last value of the 4-bit tick counter
    localparam int         TICKS_PER_BIT = 16;
    localparam logic [3:0] TICK_LAST     = 4'(TICKS_PER_BIT - 1);

    // Transmit FSM states. The TX_ prefix keeps TX_DATA apart from the DATA address
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef TX_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/tx_unit.sv
// SPART transmitter: a one-byte holding register feeds an 8N1 serializer (8E1 when TX_PARITY_EN is defined).
// Latency: txd goes low 2 clk after the accepted write; each bit lasts 16 tx_en ticks.
// Backpressure: tbr=0 while the holding register is full, and writes made then are dropped.
module tx_unit
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tbr,
    output logic       tx_busy
);

    tx_state_e  state_q, state_d;
    logic [7:0] hold_q,  hold_d;
    logic       full_q,  full_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] tick_q,  tick_d;
    logic [2:0] bit_q,   bit_d;
    logic       txd_q,   txd_d;
`ifdef TX_PARITY_EN
    logic       par_q,   par_d;
`endif

    logic wr_acc;
    logic bit_end;
    logic load;

    // Next-state logic: the write into the holding register, the transfer to the shifter, and bit sequencing
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        full_d  = full_q;
        shift_d = shift_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
`ifdef TX_PARITY_EN
        par_d   = par_q;
`endif
        load    = 1'b0;
        wr_acc  = iocs && !iorw && (ioaddr == DATA) && !full_q;
        bit_end = tx_en && (tick_q == TICK_LAST);

        // Ticks are counted only during a frame; the counter wraps at the end of each bit
        if (tx_en && state_q != TX_IDLE) begin
            tick_d = tick_q + 4'd1;
        end

        case (state_q)
            TX_IDLE: begin
                if (full_q) load = 1'b1;
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
                        state_d = TX_PARITY;
                        txd_d   = par_q;
`else
                        state_d = TX_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[1];
                    end
                end
            end
`ifdef TX_PARITY_EN
            TX_PARITY: begin
                if (bit_end) begin
                    state_d = TX_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (bit_end) begin
                    // A waiting byte starts at once, with no idle gap between frames
                    if (full_q) load = 1'b1;
                    else        state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Transfer from the holding register: its start bit is driven on this edge
        if (load) begin
            shift_d = hold_q;
            full_d  = 1'b0;
            tick_d  = 4'd0;
            state_d = TX_START;
            txd_d   = 1'b0;
`ifdef TX_PARITY_EN
            par_d   = ^hold_q;
`endif
        end

        // wr_acc needs an empty holding register and load needs a full one, so both cannot happen together
        if (wr_acc) begin
            hold_d = tx_data;
            full_d = 1'b1;
        end
    end

    // State registers; reset forces an idle line even in the middle of a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            hold_q  <= 8'd0;
            full_q  <= 1'b0;
            shift_q <= 8'd0;
            tick_q  <= 4'd0;
            bit_q   <= 3'd0;
            txd_q   <= 1'b1;
`ifdef TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            shift_q <= shift_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
`ifdef TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign txd     = txd_q;
    assign tbr     = !full_q;
    assign tx_busy = (state_q != TX_IDLE);

endmodule

// File: tb/tb_tx_unit.sv
// Directed and random frames checked against a bit-level model of the serial line.
// Latency: the model expects txd low 2 clk after the write, then one frame bit per 16 ticks.
// Backpressure: a write made while tbr=0 must not show up on the line.
module tb_tx_unit;
    import spart_pkg::*;

`ifdef TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FT = NBITS * 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx_en = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b1;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] tx_data = 8'h00;
    logic       txd, tbr, tx_busy;

    int tests = 0;
    int fails = 0;

    tx_unit dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .iocs(iocs), .iorw(iorw),
        .ioaddr(ioaddr), .tx_data(tx_data), .txd(txd), .tbr(tbr), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    // Bit idx of the frame for byte b: start, data bits LSB first, optional even parity, stop
    function automatic logic fbit(input logic [7:0] b, input int idx);
        if (idx == 0)                 return 1'b0;
        if (idx >= 1 && idx <= 8)     return b[idx-1];
        if (idx == 9 && NBITS == 11)  return ^b;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) tx_en = 1'b1;
        @(negedge clk) tx_en = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] b, input logic [1:0] addr, input logic rw, input logic cs);
        @(negedge clk);
        iocs = cs; iorw = rw; ioaddr = addr; tx_data = b;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00;
    endtask

    // Write b into an idle transmitter and follow it to the start bit
    task automatic start_frame(input logic [7:0] b);
        do_write(b, DATA, 1'b0, 1'b1);
        check("tbr_fall", tbr, 1'b0);
        check("txd_before_start", txd, 1'b1);
        @(negedge clk);
        check("tbr_rise", tbr, 1'b1);
        check("txd_start_edge", txd, 1'b0);
        check("busy_start", tx_busy, 1'b1);
    endtask

    // Ticks from..to, counted from the first transfer; frame b follows frame a when nfr==2.
    // tbr is expected low until tick tbr_at and high from that tick on.
    task automatic run_ticks(input int from, input int to, input logic [7:0] a, input logic [7:0] b,
                             input int nfr, input int tbr_at);
        for (int k = from; k <= to; k++) begin
            logic el;
            tick();
            if (k < FT)                    el = fbit(a, k / 16);
            else if (nfr == 2 && k < 2*FT) el = fbit(b, (k - FT) / 16);
            else                           el = 1'b1;
            check("txd_tick", txd, el);
            check("busy_tick", tx_busy, (k < nfr*FT) ? 1'b1 : 1'b0);
            check("tbr_tick", tbr, (k >= tbr_at) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        logic [7:0] rb;

        // Reset: the outputs respond with no clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_txd", txd, 1'b1);
        check("rst_tbr", tbr, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Ticks while idle do nothing
        for (int i = 0; i < 20; i++) tick();
        check("idle_txd", txd, 1'b1);
        check("idle_busy", tx_busy, 1'b0);

        // Writes that are not DATA writes are ignored
        do_write(8'h11, STATUS, 1'b0, 1'b1);
        @(negedge clk);
        check("wr_status_tbr", tbr, 1'b1);
        check("wr_status_busy", tx_busy, 1'b0);
        do_write(8'h22, DATA, 1'b1, 1'b1);
        @(negedge clk);
        check("rd_data_tbr", tbr, 1'b1);
        do_write(8'h33, DATA, 1'b0, 1'b0);
        @(negedge clk);
        check("nocs_tbr", tbr, 1'b1);
        check("nocs_busy", tx_busy, 1'b0);

        // Single 0x55 frame
        start_frame(8'h55);
        run_ticks(1, FT, 8'h55, 8'h00, 1, 0);

        // Random single frames
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            start_frame(rb);
            run_ticks(1, FT, rb, 8'h00, 1, 0);
        end

        // Back to back: 0xCF queued during 0x55's data bits, then 0xAA dropped
        start_frame(8'h55);
        run_ticks(1, 40, 8'h55, 8'hCF, 2, 0);
        do_write(8'hCF, DATA, 1'b0, 1'b1);
        check("b2b_tbr_held", tbr, 1'b0);
        do_write(8'hAA, DATA, 1'b0, 1'b1);
        check("drop_tbr", tbr, 1'b0);
        run_ticks(41, 2*FT, 8'h55, 8'hCF, 2, FT);

        // Parity cases when enabled; plain frames otherwise
        start_frame(8'h07);
        run_ticks(1, FT, 8'h07, 8'h00, 1, 0);

        // Reset during data bit 3, then a clean frame
        start_frame(8'h55);
        run_ticks(1, 16*4 + 5, 8'h55, 8'h00, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_txd", txd, 1'b1);
        check("midrst_tbr", tbr, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("postrst_txd", txd, 1'b1);
        check("postrst_busy", tx_busy, 1'b0);
        start_frame(8'h0F);
        run_ticks(1, FT, 8'h0F, 8'h00, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
